// File: rtl/lcd_bus_responder.sv
// Responder side of an HD44780-style character LCD bus: decodes strobes, mirrors DDRAM, models busy.
// Optional display shift and 2x40 storage are enabled by defining LCD_RESP_SHIFT_EN.
module lcd_bus_responder #(
    parameter int CMD_CYCLES   = 16,
    parameter int CLEAR_CYCLES = 64,
    parameter int EN_MIN_HIGH  = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         lcd_en,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic [7:0]   lcd_data,
    output logic [7:0]   rd_data,
    output logic [127:0] line1_buf,
    output logic [127:0] line2_buf,
    output logic [6:0]   ddram_addr,
    output logic         busy,
    output logic         display_on,
    output logic         two_line,
    output logic         cmd_strobe,
    output logic         data_strobe,
    output logic         error
);

`ifdef LCD_RESP_SHIFT_EN
    localparam int DEPTH = 40;
    localparam int IW    = 6;
`else
    localparam int DEPTH = 16;
    localparam int IW    = 4;
`endif
    localparam int HW = $clog2(EN_MIN_HIGH + 1);
    localparam logic [5:0]    DEPTH6   = 6'(DEPTH);
    localparam logic [HW-1:0] MIN_HIGH = HW'(EN_MIN_HIGH);

    logic          en_q;
    logic [HW-1:0] high_cnt;
    logic [15:0]   busy_cnt;
    logic [6:0]    addr;
    logic          inc_mode;
    logic          cgram_mode;
    logic [7:0]    row1 [DEPTH];
    logic [7:0]    row2 [DEPTH];
`ifdef LCD_RESP_SHIFT_EN
    logic [5:0]    offset;
    logic          shift_s;
`endif

    logic          fall;
    logic          runt;
    logic          status_rd;
    logic          accept;
    logic          violation;
    logic          visible;
    logic [IW-1:0] idx;
    logic [7:0]    rd_char;
    logic [6:0]    next_addr;

    // Stepping skips the invisible gaps at the end of each row and wraps between rows.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic [5:0] lo;
        lo = a[5:0];
        if (inc) begin
            if (lo >= 6'h27) return a[6] ? 7'h00 : 7'h40;
            return a + 7'd1;
        end
        if (lo == 6'h00) return a[6] ? 7'h27 : 7'h67;
        if (lo > 6'h27)  return a[6] ? 7'h67 : 7'h27;
        return a - 7'd1;
    endfunction

`ifdef LCD_RESP_SHIFT_EN
    function automatic logic [5:0] off_step(input logic [5:0] o, input logic inc);
        if (inc) return (o == 6'd39) ? 6'd0 : o + 6'd1;
        return (o == 6'd0) ? 6'd39 : o - 6'd1;
    endfunction
`endif

    assign fall       = en_q & ~lcd_en;
    assign runt       = high_cnt < MIN_HIGH;
    assign status_rd  = ~lcd_rs & lcd_rw;
    assign busy       = busy_cnt != 16'd0;
    assign accept     = fall & ~runt & (~busy | status_rd);
    assign violation  = fall & (runt | (busy & ~status_rd));
    assign visible    = addr[5:0] < DEPTH6;
    assign idx        = addr[IW-1:0];
    assign rd_char    = !visible ? 8'h20 : (addr[6] ? row2[idx] : row1[idx]);
    assign next_addr  = step_addr(addr, inc_mode);
    assign ddram_addr = addr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            en_q        <= 1'b0;
            high_cnt    <= '0;
            busy_cnt    <= 16'd0;
            addr        <= 7'h00;
            inc_mode    <= 1'b1;
            cgram_mode  <= 1'b0;
            display_on  <= 1'b0;
            two_line    <= 1'b0;
            cmd_strobe  <= 1'b0;
            data_strobe <= 1'b0;
            error       <= 1'b0;
            rd_data     <= 8'h00;
`ifdef LCD_RESP_SHIFT_EN
            offset      <= 6'd0;
            shift_s     <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                row1[i] <= 8'h20;
                row2[i] <= 8'h20;
            end
        end else begin
            en_q        <= lcd_en;
            cmd_strobe  <= 1'b0;
            data_strobe <= 1'b0;
            if (!lcd_en)
                high_cnt <= '0;
            else if (runt)
                high_cnt <= high_cnt + 1'b1;
            if (busy)
                busy_cnt <= busy_cnt - 16'd1;
            if (violation)
                error <= 1'b1;

            // Later assignments to busy_cnt override the countdown above.
            if (accept) begin
                unique case ({lcd_rs, lcd_rw})
                    2'b00: begin
                        cmd_strobe <= 1'b1;
                        busy_cnt   <= (lcd_data == 8'h01) ? 16'(CLEAR_CYCLES) : 16'(CMD_CYCLES);
                        casez (lcd_data)
                            8'b1???????: begin
                                addr       <= lcd_data[6:0];
                                cgram_mode <= 1'b0;
                            end
                            8'b01??????: cgram_mode <= 1'b1;
                            8'b001?????: two_line   <= lcd_data[3];
                            8'b0001????: begin
                                if (!lcd_data[3])
                                    addr <= step_addr(addr, lcd_data[2]);
`ifdef LCD_RESP_SHIFT_EN
                                else
                                    offset <= off_step(offset, ~lcd_data[2]);
`endif
                            end
                            8'b00001???: display_on <= lcd_data[2];
                            8'b000001??: begin
                                inc_mode <= lcd_data[1];
`ifdef LCD_RESP_SHIFT_EN
                                shift_s  <= lcd_data[0];
`endif
                            end
                            8'b0000001?: begin
                                addr <= 7'h00;
`ifdef LCD_RESP_SHIFT_EN
                                offset <= 6'd0;
`endif
                            end
                            8'b00000001: begin
                                addr       <= 7'h00;
                                inc_mode   <= 1'b1;
                                cgram_mode <= 1'b0;
`ifdef LCD_RESP_SHIFT_EN
                                offset     <= 6'd0;
`endif
                                for (int i = 0; i < DEPTH; i++) begin
                                    row1[i] <= 8'h20;
                                    row2[i] <= 8'h20;
                                end
                            end
                            default: ;
                        endcase
                    end
                    2'b01: rd_data <= {busy, addr};
                    2'b10: begin
                        data_strobe <= 1'b1;
                        busy_cnt    <= 16'(CMD_CYCLES);
                        if (!cgram_mode && visible) begin
                            if (addr[6])
                                row2[idx] <= lcd_data;
                            else
                                row1[idx] <= lcd_data;
                        end
                        addr <= next_addr;
`ifdef LCD_RESP_SHIFT_EN
                        if (shift_s)
                            offset <= off_step(offset, inc_mode);
`endif
                    end
                    default: begin
                        busy_cnt <= 16'(CMD_CYCLES);
                        rd_data  <= rd_char;
                        addr     <= next_addr;
                    end
                endcase
            end
        end
    end

    // Each visible column c shows DDRAM position c (plus the shift offset, modulo 40, when enabled).
    always_comb begin
        line1_buf = '0;
        line2_buf = '0;
        for (int c = 0; c < 16; c++) begin
`ifdef LCD_RESP_SHIFT_EN
            logic [6:0] p;
            p = 7'(c) + {1'b0, offset};
            if (p >= 7'd40)
                p = p - 7'd40;
            line1_buf[127 - 8*c -: 8] = row1[p[5:0]];
            line2_buf[127 - 8*c -: 8] = row2[p[5:0]];
`else
            line1_buf[127 - 8*c -: 8] = row1[4'(c)];
            line2_buf[127 - 8*c -: 8] = row2[4'(c)];
`endif
        end
    end

endmodule
